inst_mem_dma_loader: RTL and testbench
======================================

Name: inst_mem_dma_loader

Overview:
DMA engine that fills the L1 instruction memory from a byte stream, e.g. a boot or UART receiver. It accepts a start command with a base word index and word count. It packs incoming bytes little-endian into 32-bit words and drives the instruction memory's DMA write port (waddr/wdata/write). It holds the CPU while loading and pulses done on completion.

Parameters:
INST_WIDTH, 32, instruction word width; fixed at 4 bytes per word.
INST_ADDR_WIDTH, 32, width of the DMA write address (word index).
NUM_WORDS, 128, instruction memory depth in words; the address wraps modulo this value.
CNT_WIDTH, 8, width of the word_count and words_written fields.

Ports:
cpu_clk  input  1  sole clock; everything samples on posedge.
cpu_rst  input  1  synchronous, active-high reset.
start  input  1  1-cycle command pulse; sampled only in IDLE.
base_waddr  input  INST_ADDR_WIDTH  first word index; sampled with start.
word_count  input  CNT_WIDTH  number of words to load; sampled with start.
abort  input  1  cancels an active load.
s_byte_valid  input  1  byte stream valid.
s_byte_data  input  8  byte stream data.
s_byte_ready  output  1  byte accepted when valid&&ready at posedge.
dma_inst_mem_waddr  output  INST_ADDR_WIDTH  word index to instruction memory (not a byte address).
dma_inst_mem_wdata  output  INST_WIDTH  packed instruction word.
inst_mem_write  output  1  1-cycle write strobe to instruction memory.
busy  output  1  state != IDLE.
cpu_hold  output  1  equals busy; stalls PC fetch during the load.
done  output  1  1-cycle pulse on normal completion.
words_written  output  CNT_WIDTH  words committed in the current or last load.

Behaviour:
- Reset (cpu_rst=1 at posedge): state=IDLE. s_byte_ready, inst_mem_write, busy, cpu_hold and done are all 0. dma_inst_mem_waddr, dma_inst_mem_wdata and words_written are 0. The byte index and the partial word are cleared.
- Reset mid-load: the load aborts immediately. The partial word is discarded and no write pulse follows.
- All outputs are registered except busy, cpu_hold and s_byte_ready, which decode the state combinationally.
- States: IDLE, RECV, WRITE, DONE.
- IDLE, start=1:
  - Latch base_waddr mod NUM_WORDS into the address register and word_count into the remaining count.
  - Clear words_written and the byte index.
  - If word_count==0, go to DONE; otherwise go to RECV.
- IDLE, start=0: stay in IDLE.
- start while not in IDLE is ignored.
- RECV: s_byte_ready=1.
  - On each accepted byte with byte index k (0..3), the byte goes into wdata[8k+7:8k]; byte 0 is the LSB.
  - Bytes with valid=0 cause no change; there is no timeout.
- Byte 3 accepted (edge N):
  - Load dma_inst_mem_wdata with the full word and dma_inst_mem_waddr with the current address.
  - Set inst_mem_write=1 and go to WRITE.
  - The strobe is high for exactly the cycle after edge N, so the memory captures the word at edge N+1.
- WRITE (1 cycle): s_byte_ready=0, inst_mem_write drops to 0 at the next edge.
  - Address becomes (addr+1) mod NUM_WORDS, i.e. NUM_WORDS-1 wraps to 0.
  - remaining decrements and words_written increments.
  - If remaining was 1, go to DONE; otherwise go to RECV with byte index 0.
- Peak throughput is 1 word per 5 cycles, because ready is low during WRITE.
- DONE (1 cycle): done=1, busy=1; then go to IDLE. words_written holds its value until the next start.
- abort=1 in RECV: go to IDLE next edge without a done pulse. The partial word is dropped; words_written keeps the count of committed words.
- abort=1 in WRITE: the write already strobed completes and is counted; then go to IDLE with no done.
- abort in DONE: ignored (done still pulses).
- abort together with start in IDLE: start wins; abort has no effect outside RECV/WRITE.
- Bytes offered when ready=0 are not consumed; the upstream source must hold them.

Test Plan:
- Reset, then start base=0 count=2; bytes 13 00 00 00 93 00 10 00 -> write waddr=0 wdata=0x00000013, then waddr=1 wdata=0x00100093. done pulses once, words_written=2, busy/cpu_hold high from start until after done.
- start count=0 -> DONE next cycle, done=1 one cycle, no inst_mem_write, words_written=0.
- base=127 count=3, NUM_WORDS=128 -> writes go to waddr 127, 0, 1 (wrap).
- Deassert s_byte_valid for 5 cycles between byte 1 and byte 2 -> the packed word is unchanged by the gap. Each write strobe is exactly 1 cycle; s_byte_ready=0 during each WRITE cycle.
- Abort after 2 bytes of word 1 (count=3) -> IDLE, no write for the partial word, no done, words_written=1. Then a fresh start base=10 count=1 writes waddr=10.
- Assert cpu_rst during RECV mid-word, then release -> all outputs 0 and IDLE. start is ignored while busy; a second start during a load does not change base or count.

Source files
------------

// File: rtl/inst_mem_dma_loader.sv
// Byte-stream DMA loader: packs bytes little-endian into 32-bit words and writes them to instruction memory.
// One word per 5 cycles at best; s_byte_ready is low outside RECV, so upstream must hold its byte.
module inst_mem_dma_loader #(
  parameter int INST_WIDTH      = 32,
  parameter int INST_ADDR_WIDTH = 32,
  parameter int NUM_WORDS       = 128,
  parameter int CNT_WIDTH       = 8
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       start,
  input  logic [INST_ADDR_WIDTH-1:0] base_waddr,
  input  logic [CNT_WIDTH-1:0]       word_count,
  input  logic                       abort,
  input  logic                       s_byte_valid,
  input  logic [7:0]                 s_byte_data,
  output logic                       s_byte_ready,
  output logic [INST_ADDR_WIDTH-1:0] dma_inst_mem_waddr,
  output logic [INST_WIDTH-1:0]      dma_inst_mem_wdata,
  output logic                       inst_mem_write,
  output logic                       busy,
  output logic                       cpu_hold,
  output logic                       done,
  output logic [CNT_WIDTH-1:0]       words_written
);

  typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

  localparam logic [INST_ADDR_WIDTH-1:0] NW = INST_ADDR_WIDTH'(NUM_WORDS);

  state_t                     state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]       rem_q, rem_d;
  logic [CNT_WIDTH-1:0]       ww_q, ww_d;
  logic [1:0]                 idx_q, idx_d;
  logic [INST_WIDTH-1:0]      word_q, word_d;
  logic [INST_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [INST_WIDTH-1:0]      wdata_q, wdata_d;
  logic                       write_q, write_d;
  logic                       done_q, done_d;

  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      ww_q    <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      ww_q    <= ww_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    ww_d    = ww_q;
    idx_d   = idx_q;
    word_d  = word_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    write_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_waddr % NW;
          rem_d   = word_count;
          ww_d    = '0;
          idx_d   = '0;
          word_d  = '0;
          state_d = (word_count == '0) ? DONE : RECV;
        end
      end
      RECV: begin
        // Abort wins over a byte offered in the same cycle; that byte is dropped.
        if (abort) begin
          state_d = IDLE;
        end else if (s_byte_valid) begin
          word_d[8*idx_q +: 8] = s_byte_data;
          idx_d                = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            wdata_d = {s_byte_data, word_q[INST_WIDTH-9:0]};
            waddr_d = addr_q;
            write_d = 1'b1;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        addr_d = (addr_q == NW - INST_ADDR_WIDTH'(1)) ? '0 : addr_q + INST_ADDR_WIDTH'(1);
        rem_d  = rem_q - CNT_WIDTH'(1);
        ww_d   = ww_q + CNT_WIDTH'(1);
        idx_d  = '0;
        if (abort)                         state_d = IDLE;
        else if (rem_q == CNT_WIDTH'(1))   state_d = DONE;
        else                               state_d = RECV;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE);
  end

  assign busy               = (state_q != IDLE);
  assign cpu_hold           = busy;
  assign s_byte_ready       = (state_q == RECV);
  assign dma_inst_mem_waddr = waddr_q;
  assign dma_inst_mem_wdata = wdata_q;
  assign inst_mem_write     = write_q;
  assign done               = done_q;
  assign words_written      = ww_q;

endmodule

// File: tb/tb_inst_mem_dma_loader.sv
// Bench for inst_mem_dma_loader: table of load commands plus hand-written abort/reset/restart sequences,
// with a write scoreboard checked whenever the DUT strobes inst_mem_write.
module tb_inst_mem_dma_loader;

  localparam int NW = 128;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        start;
  logic [31:0] base_waddr;
  logic [7:0]  word_count;
  logic        abort;
  logic        s_byte_valid;
  logic [7:0]  s_byte_data;
  logic        s_byte_ready;
  logic [31:0] dma_inst_mem_waddr;
  logic [31:0] dma_inst_mem_wdata;
  logic        inst_mem_write;
  logic        busy;
  logic        cpu_hold;
  logic        done;
  logic [7:0]  words_written;

  inst_mem_dma_loader #(
    .INST_WIDTH(32), .INST_ADDR_WIDTH(32), .NUM_WORDS(NW), .CNT_WIDTH(8)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .start(start), .base_waddr(base_waddr),
    .word_count(word_count), .abort(abort), .s_byte_valid(s_byte_valid),
    .s_byte_data(s_byte_data), .s_byte_ready(s_byte_ready),
    .dma_inst_mem_waddr(dma_inst_mem_waddr), .dma_inst_mem_wdata(dma_inst_mem_wdata),
    .inst_mem_write(inst_mem_write), .busy(busy), .cpu_hold(cpu_hold), .done(done),
    .words_written(words_written)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [31:0]      base;
    logic [7:0]       count;
    logic [31:0]      exp_addr0;
    logic [3:0][31:0] words;
    int               gap_k;
    bit               abort_with_start;
  } vec_t;

  int  checks = 0;
  int  errors = 0;
  wr_t exp_q[$];
  wr_t mon_e;
  int  done_cnt = 0;
  bit  prev_wr = 1'b0;
  bit  prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard side: every write strobe must match the oldest expected write.
  always @(negedge cpu_clk) begin
    if (inst_mem_write === 1'b1) begin
      check("strobe_single_cycle", {31'b0, prev_wr}, 32'd0);
      check("ready_low_in_write", {31'b0, s_byte_ready}, 32'd0);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: waddr 0x%08h wdata 0x%08h with no write expected",
                 dma_inst_mem_waddr, dma_inst_mem_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        check("waddr", dma_inst_mem_waddr, mon_e.a);
        check("wdata", dma_inst_mem_wdata, mon_e.d);
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      check("done_single_cycle", {31'b0, prev_done}, 32'd0);
    end
    prev_wr   = (inst_mem_write === 1'b1);
    prev_done = (done === 1'b1);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit r;
    bit ok;
    ok = 1'b0;
    s_byte_valid = 1'b1;
    s_byte_data  = b;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge cpu_clk);
      r = s_byte_ready;
      @(posedge cpu_clk);
      #1;
      ok = r;
    end
    s_byte_valid = 1'b0;
    s_byte_data  = 8'hA5;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_accept_timeout: byte 0x%02h not accepted within 20 cycles", b);
    end
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic send_word(input logic [31:0] a, input logic [31:0] w, input int gap_k);
    logic [31:0] wv;
    wv = w;
    for (int k = 0; k < 4; k++) begin
      send_byte(wv[8*k +: 8]);
      if (k == 3) push_exp(a, wv);
      if (k == gap_k) begin
        for (int g = 0; g < 5; g++) begin
          s_byte_data = 8'hFF;
          tick();
        end
      end
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = -1;
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) begin
        cyc = i;
        break;
      end
      tick();
    end
  endtask

  task automatic do_start(input logic [31:0] b, input logic [7:0] c, input bit ab);
    base_waddr = b;
    word_count = c;
    start      = 1'b1;
    abort      = ab;
    tick();
    start      = 1'b0;
    abort      = 1'b0;
  endtask

  task automatic run_load(input vec_t v);
    int          dc0;
    int          cyc;
    logic [31:0] a;
    dc0 = done_cnt;
    do_start(v.base, v.count, v.abort_with_start);
    check("busy_after_start", {31'b0, busy}, 32'd1);
    check("hold_after_start", {31'b0, cpu_hold}, 32'd1);
    check("done_at_start", {31'b0, done}, (v.count == 8'd0) ? 32'd1 : 32'd0);
    a = v.exp_addr0;
    for (int w = 0; w < int'(v.count); w++) begin
      send_word(a, v.words[w], (w == 0) ? v.gap_k : -1);
      a = (a + 32'd1) % NW;
    end
    wait_done(cyc);
    check("done_latency", cyc, (v.count == 8'd0) ? 32'd0 : 32'd1);
    check("words_written", {24'b0, words_written}, {24'b0, v.count});
    check("busy_in_done", {31'b0, busy}, 32'd1);
    tick();
    check("done_pulses", done_cnt - dc0, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);
    check("idle_hold", {31'b0, cpu_hold}, 32'd0);
    check("ww_holds", {24'b0, words_written}, {24'b0, v.count});
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  function automatic vec_t mk(input logic [31:0] base, input logic [7:0] cnt, input logic [31:0] a0,
                              input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                              input int gap_k, input bit aws);
    vec_t r;
    r.base             = base;
    r.count            = cnt;
    r.exp_addr0        = a0;
    r.words            = {32'h0, w2, w1, w0};
    r.gap_k            = gap_k;
    r.abort_with_start = aws;
    return r;
  endfunction

  vec_t vecs[6];
  int   dc0;
  int   cyc;

  initial begin
    vecs[0] = mk(32'd0,   8'd2, 32'd0,   32'h0000_0013, 32'h0010_0093, 32'h0,         -1, 1'b0);
    vecs[1] = mk(32'd0,   8'd0, 32'd0,   32'h0,         32'h0,         32'h0,         -1, 1'b0);
    vecs[2] = mk(32'd127, 8'd3, 32'd127, 32'hCAFE_0001, 32'h1234_5678, 32'h8765_4321, -1, 1'b0);
    vecs[3] = mk(32'd5,   8'd1, 32'd5,   32'hDEAD_BEEF, 32'h0,         32'h0,          1, 1'b0);
    vecs[4] = mk(32'd200, 8'd2, 32'd72,  32'hA1B2_C3D4, 32'h0F0E_0D0C, 32'h0,         -1, 1'b0);
    vecs[5] = mk(32'd3,   8'd1, 32'd3,   32'h5566_7788, 32'h0,         32'h0,         -1, 1'b1);

    cpu_rst      = 1'b1;
    start        = 1'b0;
    abort        = 1'b0;
    base_waddr   = '0;
    word_count   = '0;
    s_byte_valid = 1'b0;
    s_byte_data  = '0;
    tick();
    tick();
    check("rst_ready", {31'b0, s_byte_ready}, 32'd0);
    check("rst_write", {31'b0, inst_mem_write}, 32'd0);
    check("rst_busy",  {31'b0, busy}, 32'd0);
    check("rst_hold",  {31'b0, cpu_hold}, 32'd0);
    check("rst_done",  {31'b0, done}, 32'd0);
    check("rst_waddr", dma_inst_mem_waddr, 32'd0);
    check("rst_wdata", dma_inst_mem_wdata, 32'd0);
    check("rst_ww",    {24'b0, words_written}, 32'd0);
    cpu_rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_load(vecs[i]);

    // Abort two bytes into the second word: one committed write, no done.
    dc0 = done_cnt;
    do_start(32'd20, 8'd3, 1'b0);
    send_word(32'd20, 32'h1122_3344, -1);
    send_byte(8'h99);
    send_byte(8'h88);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'b0, busy}, 32'd0);
    check("abort_ready", {31'b0, s_byte_ready}, 32'd0);
    check("abort_ww", {24'b0, words_written}, 32'd1);
    repeat (4) tick();
    check("abort_no_done", done_cnt - dc0, 32'd0);
    check("abort_queue", exp_q.size(), 32'd0);
    run_load(mk(32'd10, 8'd1, 32'd10, 32'h0BAD_F00D, 32'h0, 32'h0, -1, 1'b0));

    // Reset in the middle of a word.
    dc0 = done_cnt;
    do_start(32'd30, 8'd2, 1'b0);
    send_byte(8'h01);
    send_byte(8'h02);
    cpu_rst = 1'b1;
    tick();
    cpu_rst = 1'b0;
    check("mrst_ready", {31'b0, s_byte_ready}, 32'd0);
    check("mrst_write", {31'b0, inst_mem_write}, 32'd0);
    check("mrst_busy",  {31'b0, busy}, 32'd0);
    check("mrst_hold",  {31'b0, cpu_hold}, 32'd0);
    check("mrst_done",  {31'b0, done}, 32'd0);
    check("mrst_waddr", dma_inst_mem_waddr, 32'd0);
    check("mrst_wdata", dma_inst_mem_wdata, 32'd0);
    check("mrst_ww",    {24'b0, words_written}, 32'd0);
    repeat (4) tick();
    check("mrst_no_done", done_cnt - dc0, 32'd0);

    // start pulses during RECV and WRITE must not disturb the running load.
    dc0 = done_cnt;
    do_start(32'd40, 8'd2, 1'b0);
    send_byte(8'hEF);
    send_byte(8'hBE);
    do_start(32'd90, 8'd1, 1'b0);
    send_byte(8'hAD);
    send_byte(8'hDE);
    push_exp(32'd40, 32'hDEAD_BEEF);
    do_start(32'd91, 8'd1, 1'b0);
    send_word(32'd41, 32'h0102_0304, -1);
    wait_done(cyc);
    check("restart_done_latency", cyc, 32'd1);
    check("restart_ww", {24'b0, words_written}, 32'd2);
    tick();
    check("restart_done_pulses", done_cnt - dc0, 32'd1);
    check("restart_queue", exp_q.size(), 32'd0);
    check("restart_idle", {31'b0, busy}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
